// File: rtl/axi_sort_periph.sv
// AXI4-lite slave wrapping an N-entry buffer and an in-place odd-even transposition sorter.
// Firmware loads DATA[], starts via CTRL, then polls STATUS or waits for irq before reading back.
module axi_sort_periph #(
   parameter int unsigned LOG_N     = 4,
   parameter int unsigned DATAWIDTH = 32,
   parameter bit          SIGNED    = 1'b0,
   parameter bit          ASCENDING = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [11:0] s_axi_awaddr,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [11:0] s_axi_araddr,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        irq
);

   localparam int unsigned N = 1 << LOG_N;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   typedef enum logic [0:0] {StIdle, StSort} state_e;

   state_e r_state, w_state_nxt;

   logic [DATAWIDTH-1:0] r_buf [N];
   logic [DATAWIDTH-1:0] w_sort_buf [N];
   logic [DATAWIDTH-1:0] w_merged;

   logic        r_bvalid, r_rvalid, r_irq_en, r_done, r_phase, r_noswap;
   logic [1:0]  r_bresp, r_rresp;
   logic [31:0] r_rdata, r_cycles;

   logic        w_busy, w_sort_en, w_sort_last, w_any_swap;
   logic        w_wr_fire, w_rd_fire, w_ctrl_wr, w_clear, w_start_req, w_start, w_start_err;
   logic        w_data_wr, w_data_err, w_done_w1c, w_wr_data_hit, w_rd_data_hit;
   logic [9:0]  w_wr_word, w_wr_off, w_rd_word, w_rd_off;
   logic [LOG_N-1:0] w_wr_idx, w_rd_idx;
   logic [1:0]  w_bresp, w_rd_resp;
   logic [31:0] w_rd_data, w_cycles_nxt;
   logic        w_unused;

   function automatic logic f_out_of_order(input logic [DATAWIDTH-1:0] a,
                                           input logic [DATAWIDTH-1:0] b);
      logic a_gt_b, a_lt_b;
      if (SIGNED) begin
         a_gt_b = $signed(a) > $signed(b);
         a_lt_b = $signed(a) < $signed(b);
      end else begin
         a_gt_b = a > b;
         a_lt_b = a < b;
      end
      return ASCENDING ? a_gt_b : a_lt_b;
   endfunction

   function automatic logic [31:0] f_ext(input logic [DATAWIDTH-1:0] v);
      if (SIGNED) return 32'(signed'(v));
      return 32'(v);
   endfunction

   // Write channel: address and data must arrive together; one response outstanding.
   assign w_wr_fire     = s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
   assign s_axi_awready = w_wr_fire;
   assign s_axi_wready  = w_wr_fire;
   assign w_rd_fire     = s_axi_arvalid & ~r_rvalid;
   assign s_axi_arready = w_rd_fire;

   assign w_wr_word     = s_axi_awaddr[11:2];
   assign w_wr_off      = w_wr_word - 10'h040;
   assign w_wr_data_hit = (w_wr_word >= 10'h040) && (w_wr_off < 10'(N));
   assign w_wr_idx      = w_wr_off[LOG_N-1:0];
   assign w_rd_word     = s_axi_araddr[11:2];
   assign w_rd_off      = w_rd_word - 10'h040;
   assign w_rd_data_hit = (w_rd_word >= 10'h040) && (w_rd_off < 10'(N));
   assign w_rd_idx      = w_rd_off[LOG_N-1:0];

   // Clear beats start when both bits are set in the same write.
   assign w_ctrl_wr   = w_wr_fire & (w_wr_word == 10'd0) & s_axi_wstrb[0];
   assign w_clear     = w_ctrl_wr & s_axi_wdata[1];
   assign w_start_req = w_ctrl_wr & s_axi_wdata[0] & ~s_axi_wdata[1];
   assign w_start_err = w_start_req & w_busy;
   assign w_start     = w_start_req & ~w_busy;
   assign w_data_err  = w_wr_fire & w_wr_data_hit & w_busy;
   assign w_data_wr   = w_wr_fire & w_wr_data_hit & ~w_busy;
   assign w_done_w1c  = w_wr_fire & (w_wr_word == 10'd1) & s_axi_wstrb[0] & s_axi_wdata[1];

   always_comb begin
      w_bresp = RespOkay;
      if ((w_wr_word >= 10'd4) && !w_wr_data_hit) w_bresp = RespDecErr;
      else if (w_start_err || w_data_err)          w_bresp = RespSlvErr;
   end

   always_comb begin
      w_merged = r_buf[w_wr_idx];
      for (int b = 0; b < int'(DATAWIDTH); b++) begin
         if (s_axi_wstrb[b / 8]) w_merged[b] = s_axi_wdata[b];
      end
   end

   // One transposition phase: even phases pair (0,1),(2,3)..; odd phases (1,2),(3,4)..
   always_comb begin
      w_sort_buf = r_buf;
      w_any_swap = 1'b0;
      for (int i = 0; i < int'(N) - 1; i++) begin
         if (((i % 2) == int'(r_phase)) && f_out_of_order(r_buf[i], r_buf[i + 1])) begin
            w_sort_buf[i]     = r_buf[i + 1];
            w_sort_buf[i + 1] = r_buf[i];
            w_any_swap        = 1'b1;
         end
      end
   end

   assign w_cycles_nxt = r_cycles + 32'd1;
   assign w_sort_last  = w_sort_en & ((w_cycles_nxt == 32'(N)) | (~w_any_swap & r_noswap));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= StIdle;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: if (w_start) w_state_nxt = StSort;
         StSort: if (w_clear || w_sort_last) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_busy    = (r_state == StSort);
      w_sort_en = (r_state == StSort) & ~w_clear;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
      end else if (w_clear) begin
         for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
      end else if (w_sort_en) begin
         r_buf <= w_sort_buf;
      end else if (w_data_wr) begin
         r_buf[w_wr_idx] <= w_merged;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_cycles <= '0;
         r_phase  <= 1'b0;
         r_noswap <= 1'b0;
      end else begin
         if (w_ctrl_wr && !w_start_err) r_irq_en <= s_axi_wdata[2];
         if (w_clear || w_start) begin
            r_done   <= 1'b0;
            r_cycles <= '0;
            r_phase  <= 1'b0;
            r_noswap <= 1'b0;
         end else begin
            if (w_sort_last)     r_done <= 1'b1;
            else if (w_done_w1c) r_done <= 1'b0;
            if (w_sort_en) begin
               r_cycles <= w_cycles_nxt;
               r_phase  <= ~r_phase;
               r_noswap <= ~w_any_swap;
            end
         end
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RespOkay;
      case (w_rd_word)
         10'd0:   w_rd_data = {29'b0, r_irq_en, 2'b0};
         10'd1:   w_rd_data = {30'b0, r_done, w_busy};
         10'd2:   w_rd_data = r_cycles;
         10'd3:   w_rd_data = {16'b0, SIGNED, ASCENDING, 6'b0, 8'(LOG_N)};
         default: begin
            if (w_rd_data_hit) w_rd_data = f_ext(r_buf[w_rd_idx]);
            else               w_rd_resp = RespDecErr;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RespOkay;
         r_rvalid <= 1'b0;
         r_rresp  <= RespOkay;
         r_rdata  <= '0;
      end else begin
         if (w_wr_fire) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_bresp;
         end else if (s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
         end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign s_axi_bvalid = r_bvalid;
   assign s_axi_bresp  = r_bresp;
   assign s_axi_rvalid = r_rvalid;
   assign s_axi_rresp  = r_rresp;
   assign s_axi_rdata  = r_rdata;
   assign irq          = r_done & r_irq_en;

   assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, s_axi_wstrb};

endmodule

// File: tb/tb_axi_sort_periph.sv
// Bench for axi_sort_periph (N=16, 16-bit signed elements): bus transactions push expected
// responses into queues, negedge monitors pop and compare when the DUT answers.
module tb_axi_sort_periph;

   localparam int LOG_N = 4;
   localparam int N     = 16;
   localparam int DW    = 16;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   logic        clk = 1'b0;
   logic        resetn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, irq;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0]    bq[$];
   string         bq_tag[$];
   logic [33:0]   rq[$];
   string         rq_tag[$];
   logic [DW-1:0] m_buf [N];
   int            stim [N];

   logic [1:0]  mon_bexp;
   logic [33:0] mon_rexp;
   string       mon_tag;

   axi_sort_periph #(
      .LOG_N(LOG_N), .DATAWIDTH(DW), .SIGNED(1'b1), .ASCENDING(1'b1)
   ) u_dut (
      .clk(clk), .resetn(resetn),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (bq.size() == 0) check_eq("bresp_unexpected", 32'(bq.size()), 32'd1);
         else begin
            mon_bexp = bq.pop_front();
            mon_tag  = bq_tag.pop_front();
            check_eq({mon_tag, "_bresp"}, {30'b0, bresp}, {30'b0, mon_bexp});
         end
      end
      if (rvalid && rready) begin
         if (rq.size() == 0) check_eq("rdata_unexpected", 32'(rq.size()), 32'd1);
         else begin
            mon_rexp = rq.pop_front();
            mon_tag  = rq_tag.pop_front();
            check_eq({mon_tag, "_rdata"}, rdata, mon_rexp[31:0]);
            check_eq({mon_tag, "_rresp"}, {30'b0, rresp}, {30'b0, mon_rexp[33:32]});
         end
      end
   end

   function automatic logic [31:0] ext(input logic [DW-1:0] v);
      return {{(32 - DW){v[DW-1]}}, v};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [31:0] d,
                                           input logic [3:0] strb);
      logic [31:0] w;
      w = {{(32 - DW){1'b0}}, old};
      for (int j = 0; j < 4; j++) if (strb[j]) w[8*j +: 8] = d[8*j +: 8];
      return w[DW-1:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp,
                            input int lead = 0, input int bdly = 0);
      int t;
      bq.push_back(exp);
      bq_tag.push_back(tag);
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = data; wstrb = strb;
      for (int k = 0; k < lead; k++) begin
         @(negedge clk);
         check_eq({tag, "_wready_lone"}, {31'b0, wready}, 32'd0);
         @(posedge clk); #1;
      end
      awvalid = 1'b1; awaddr = addr;
      t = 0;
      @(negedge clk);
      while (!awready && t < 50) begin
         t++;
         @(negedge clk);
      end
      check_eq({tag, "_awready"}, {31'b0, awready}, 32'd1);
      check_eq({tag, "_wready"}, {31'b0, wready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (bdly > 0) begin
         tick(bdly - 1);
         @(negedge clk);
         check_eq({tag, "_bvalid_held"}, {31'b0, bvalid}, 32'd1);
         @(posedge clk); #1;
      end
      bready = 1'b1;
      t = 0;
      while (bq.size() != 0 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (bq.size() != 0) begin
         check_eq({tag, "_b_timeout"}, 32'(bq.size()), 32'd0);
         bq.delete();
         bq_tag.delete();
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input string tag, input logic [11:0] addr, input logic [31:0] exp_d,
                           input logic [1:0] exp_r = OKAY);
      int t;
      rq.push_back({exp_r, exp_d});
      rq_tag.push_back(tag);
      @(posedge clk); #1;
      arvalid = 1'b1; araddr = addr;
      t = 0;
      @(negedge clk);
      while (!arready && t < 50) begin
         t++;
         @(negedge clk);
      end
      check_eq({tag, "_arready"}, {31'b0, arready}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      rready  = 1'b1;
      t = 0;
      while (rq.size() != 0 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (rq.size() != 0) begin
         check_eq({tag, "_r_timeout"}, 32'(rq.size()), 32'd0);
         rq.delete();
         rq_tag.delete();
      end
      rready = 1'b0;
   endtask

   task automatic load_stim(input string tag);
      for (int i = 0; i < N; i++) begin
         m_buf[i] = DW'(stim[i]);
         axi_write($sformatf("%s_ld%0d", tag, i), 12'h100 + 12'(4 * i), 32'(stim[i]), 4'hF, OKAY);
      end
   endtask

   // Reference result: plain insertion sort, signed ascending.
   task automatic sort_model();
      logic [DW-1:0] key;
      int j;
      for (int i = 1; i < N; i++) begin
         key = m_buf[i];
         j = i - 1;
         while (j >= 0 && $signed(m_buf[j]) > $signed(key)) begin
            m_buf[j + 1] = m_buf[j];
            j--;
         end
         m_buf[j + 1] = key;
      end
   endtask

   task automatic check_data(input string tag);
      for (int i = 0; i < N; i++)
         axi_read($sformatf("%s_d%0d", tag, i), 12'h100 + 12'(4 * i), ext(m_buf[i]));
   endtask

   task automatic set_reversed();
      for (int i = 0; i < N; i++) stim[i] = N - 1 - i;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] v;
      int t;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check_eq("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check_eq("rst_irq", {31'b0, irq}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      #2 resetn = 1'b1;
      for (int i = 0; i < N; i++) m_buf[i] = '0;

      axi_read("rst_ctrl", 12'h000, 32'h0);
      axi_read("rst_status", 12'h004, 32'h0);
      axi_read("rst_cycles", 12'h008, 32'h0);
      axi_read("info", 12'h00C, 32'h0000_C004);
      axi_read("rst_data5", 12'h114, 32'h0);

      // Width truncation and byte strobes.
      v = merge('0, 32'h1234_5678, 4'hF);
      axi_write("wid_full", 12'h100, 32'h1234_5678, 4'hF, OKAY);
      axi_read("wid_full", 12'h100, ext(v));
      v = merge(v, 32'hAB00_9A00, 4'b0010);
      axi_write("strb_b1", 12'h100, 32'hAB00_9A00, 4'b0010, OKAY);
      axi_read("strb_b1", 12'h100, ext(v));
      v = merge(v, 32'h00FF_0000, 4'b0100);
      axi_write("strb_b2", 12'h102, 32'h00FF_0000, 4'b0100, OKAY);
      axi_read("strb_b2", 12'h100, ext(v));

      // Reversed input takes the full N phases.
      set_reversed();
      load_stim("t1");
      axi_write("t1_start", 12'h000, 32'h1, 4'h1, OKAY);
      axi_read("t1_busy", 12'h004, 32'h1);
      tick(40);
      axi_read("t1_done", 12'h004, 32'h2);
      axi_read("t1_cycles", 12'h008, 32'd16);
      sort_model();
      check_data("t1");

      // Already sorted: early exit after two quiet phases.
      for (int i = 0; i < N; i++) stim[i] = i;
      load_stim("t2");
      axi_write("t2_start", 12'h000, 32'h1, 4'h1, OKAY);
      tick(20);
      axi_read("t2_done", 12'h004, 32'h2);
      axi_read("t2_cycles", 12'h008, 32'd2);
      check_data("t2");

      // Signed ordering and sign-extended readback.
      stim = '{-1, 5, -8, 0, 3, -2, 7, 1, -5, 2, 6, -7, 4, -3, 9, -4};
      load_stim("t3");
      axi_write("t3_start", 12'h000, 32'h1, 4'h1, OKAY);
      tick(40);
      axi_read("t3_done", 12'h004, 32'h2);
      sort_model();
      check_data("t3");
      axi_read("t3_min", 12'h100, 32'hFFFF_FFF8);

      // Busy protection and decode errors.
      set_reversed();
      load_stim("t4");
      axi_write("t4_start", 12'h000, 32'h1, 4'h1, OKAY);
      axi_write("t4_data_busy", 12'h10C, 32'h0000_7777, 4'hF, SLVERR);
      axi_write("t4_start_busy", 12'h000, 32'h1, 4'h1, SLVERR);
      axi_read("t4_unmapped", 12'h200, 32'h0, DECERR);
      axi_write("t4_unmapped", 12'h200, 32'h1, 4'hF, DECERR);
      tick(40);
      axi_read("t4_done", 12'h004, 32'h2);
      axi_read("t4_cycles", 12'h008, 32'd16);
      sort_model();
      check_data("t4");

      // Interrupt follows done, cleared by W1C.
      axi_write("t5_w1c0", 12'h004, 32'h2, 4'h1, OKAY);
      axi_read("t5_status0", 12'h004, 32'h0);
      axi_write("t5_irqen", 12'h000, 32'h4, 4'h1, OKAY);
      axi_read("t5_ctrl", 12'h000, 32'h4);
      set_reversed();
      load_stim("t5");
      axi_write("t5_start", 12'h000, 32'h5, 4'h1, OKAY);
      @(negedge clk);
      check_eq("t5_irq_low", {31'b0, irq}, 32'd0);
      t = 0;
      while (!irq && t < 60) begin
         t++;
         @(negedge clk);
      end
      check_eq("t5_irq_rise", {31'b0, irq}, 32'd1);
      axi_read("t5_done", 12'h004, 32'h2);
      axi_write("t5_w1c", 12'h004, 32'h2, 4'h1, OKAY);
      @(negedge clk);
      check_eq("t5_irq_fall", {31'b0, irq}, 32'd0);
      axi_read("t5_ctrl_kept", 12'h000, 32'h4);
      axi_write("t5_irqoff", 12'h000, 32'h0, 4'h1, OKAY);

      // Lone W, slow bready, clear mid-sort.
      load_stim("t6");
      axi_write("t6_start", 12'h000, 32'h1, 4'h1, OKAY);
      axi_write("t6_clear", 12'h000, 32'h2, 4'h1, OKAY, 3, 4);
      axi_read("t6_status", 12'h004, 32'h0);
      axi_read("t6_cycles", 12'h008, 32'h0);
      for (int i = 0; i < N; i++) m_buf[i] = '0;
      check_data("t6");

      // Asynchronous reset in the middle of a sort.
      load_stim("t7");
      axi_write("t7_start", 12'h000, 32'h5, 4'h1, OKAY);
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      check_eq("t7_rst_irq", {31'b0, irq}, 32'd0);
      check_eq("t7_rst_bvalid", {31'b0, bvalid}, 32'd0);
      @(posedge clk); #2;
      resetn = 1'b1;
      axi_read("t7_status", 12'h004, 32'h0);
      axi_read("t7_ctrl", 12'h000, 32'h0);
      axi_read("t7_cycles", 12'h008, 32'h0);
      axi_read("t7_d0", 12'h100, 32'h0);
      axi_read("t7_d15", 12'h13C, 32'h0);

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
